// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the transmit and receive sides
// Contents: 3-bit FSM state encodings, default oversample ratio, line levels.
package uart_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam int OS_DEFAULT = 16;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: oversample counter that flags the last clock of each serial bit
// Ports: clk, rst (sync, active-high), clr (force count to 0), en (count),
//        bit_end (high on the clock where the count is OVERSAMPLE-1).
module uart_bit_timer import uart_pkg::*; #(
  parameter int OVERSAMPLE = OS_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_end
);
  logic [3:0] os_cnt;
  assign bit_end = en && !clr && os_cnt == 4'(OVERSAMPLE - 1);
  always_ff @(posedge clk)
    os_cnt <= (rst || clr || bit_end) ? 4'd0 : en ? os_cnt + 4'd1 : os_cnt;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: framed serial transmitter fed by a valid/ready word interface
// Ports: tx_Clk oversample clock, tx_Rst sync active-high reset, enable (low aborts),
//        i_TX_byte/i_TX_valid/o_TX_ready word input, o_TX_serial registered line,
//        o_TX_active frame in progress, o_TX_done pulse on the final stop-bit clock.
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx import uart_pkg::*; #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OS_DEFAULT,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 tx_Clk,
  input  logic                 tx_Rst,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] i_TX_byte,
  input  logic                 i_TX_valid,
  output logic                 o_TX_ready,
  output logic                 o_TX_serial,
  output logic                 o_TX_active,
  output logic                 o_TX_done
);
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  logic [2:0] state;
  logic [3:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic parity, armed, running, bit_end, last_data, last_stop, accept;
  // armed is low during reset and for one clock after enable returns, so a
  // word offered as enable rises is taken one cycle later
  assign running = enable && state != S_IDLE;
  assign o_TX_ready = enable && armed && state == S_IDLE;
  assign accept = i_TX_valid && o_TX_ready;
  assign last_data = bit_cnt == 4'(DATA_BITS - 1);
  assign last_stop = bit_cnt == 4'(STOP_BITS - 1);
  assign o_TX_done = bit_end && state == S_STOP && last_stop;
  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .clk(tx_Clk),
    .rst(tx_Rst),
    .clr(!running),
    .en(running),
    .bit_end(bit_end)
  );
  always_ff @(posedge tx_Clk) begin
    if (tx_Rst) begin
      state <= S_IDLE;
      bit_cnt <= 4'd0;
      shreg <= '0;
      parity <= 1'b0;
      armed <= 1'b0;
      o_TX_serial <= LINE_IDLE;
      o_TX_active <= 1'b0;
    end else if (!enable) begin
      state <= S_IDLE;
      bit_cnt <= 4'd0;
      armed <= 1'b0;
      o_TX_serial <= LINE_IDLE;
      o_TX_active <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE: if (accept) begin
          shreg <= i_TX_byte;
          parity <= ^i_TX_byte ^ 1'(PARITY_ODD);
          bit_cnt <= 4'd0;
          state <= S_START;
          o_TX_serial <= START_LVL;
          o_TX_active <= 1'b1;
        end
        S_START: if (bit_end) begin
          state <= S_DATA;
          o_TX_serial <= shreg[0];
        end
        // the register already holds bit n, so the next line value is shreg[1]
        S_DATA: if (bit_end) begin
          shreg <= shreg >> 1;
          bit_cnt <= last_data ? 4'd0 : bit_cnt + 4'd1;
          state <= last_data ? (PAR_EN ? S_PARITY : S_STOP) : S_DATA;
          o_TX_serial <= last_data ? (PAR_EN ? parity : LINE_IDLE) : shreg[1];
        end
        S_PARITY: if (bit_end) begin
          state <= S_STOP;
          o_TX_serial <= LINE_IDLE;
        end
        S_STOP: if (bit_end) begin
          bit_cnt <= last_stop ? 4'd0 : bit_cnt + 4'd1;
          state <= last_stop ? S_IDLE : S_STOP;
          o_TX_active <= !last_stop;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with a loopback receiver scoreboard
module tb_uart_tx;
  localparam int DB = 8, OS = 16, SB = 1, PODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 1 + DB + P + SB;
  localparam int FL = NB * OS;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b1, valid = 1'b0;
  logic [DB-1:0] data = '0;
  logic ready, serial, active, done;
  int checks = 0, errors = 0, rx_words = 0, sent = 0;
  logic [DB-1:0] q[$];
  bit rx_en = 1'b0;
  typedef struct { logic [DB-1:0] d; bit keep; logic [9:0] frame; } vec_t;
  vec_t tbl[6];
  uart_tx #(.DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(SB), .PARITY_ODD(PODD)) dut (
    .tx_Clk(clk), .tx_Rst(rst), .enable(enable), .i_TX_byte(data), .i_TX_valid(valid),
    .o_TX_ready(ready), .o_TX_serial(serial), .o_TX_active(active), .o_TX_done(done)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic exp_bit(input logic [DB-1:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= DB) return d[b-1];
    if (P == 1 && b == DB + 1) return ^d ^ 1'(PODD);
    return 1'b1;
  endfunction
  // loopback receiver: samples mid-bit and checks each decoded frame against the queue
  bit busy = 1'b0;
  int rc = 0;
  logic [NB-1:0] rbits;
  always @(negedge clk) begin
    if (!rx_en) busy = 1'b0;
    else if (!busy) begin
      if (serial == 1'b0) begin busy = 1'b1; rc = 0; end
    end else rc++;
    if (rx_en && busy && rc % OS == OS / 2) begin
      rbits[rc / OS] = serial;
      if (rc / OS == NB - 1) begin
        logic [NB-1:0] e;
        busy = 1'b0;
        rx_words++;
        if (q.size() == 0) check("rx unexpected frame", 32'(rbits), 32'hFFFFFFFF);
        else begin
          logic [DB-1:0] w;
          w = q.pop_front();
          for (int b = 0; b < NB; b++) e[b] = exp_bit(w, b);
          check("rx frame", 32'(rbits), 32'(e));
        end
      end
    end
  end
  task automatic send(input logic [DB-1:0] d, input bit keep, input bit push);
    int n = 0;
    data = d;
    valid = 1'b1;
    while (!ready && n < 4 * FL) begin @(negedge clk); n++; end
    check("ready before accept", 32'(ready), 32'd1);
    if (push) begin q.push_back(d); sent++; end
    @(negedge clk);
    valid = keep;
    data = ~d;
  endtask
  task automatic check_frame(input logic [DB-1:0] d, output logic [NB-1:0] cap);
    for (int c = 0; c < FL; c++) begin
      check("serial", 32'(serial), 32'(exp_bit(d, c / OS)));
      check("active", 32'(active), 32'd1);
      check("done", 32'(done), 32'(c == FL - 1));
      if (c % OS == OS / 2) cap[c / OS] = serial;
      @(negedge clk);
    end
    check("idle serial", 32'(serial), 32'd1);
    check("idle active", 32'(active), 32'd0);
    check("ready after frame", 32'(ready), 32'd1);
    check("done after frame", 32'(done), 32'd0);
  endtask
  initial begin
    logic [NB-1:0] cap;
    tbl[0] = '{8'h00, 1'b0, 10'b1_00000000_0};
    tbl[1] = '{8'h55, 1'b1, 10'b1_01010101_0};
    tbl[2] = '{8'hFF, 1'b1, 10'b1_11111111_0};
    tbl[3] = '{8'hA5, 1'b0, 10'b1_10100101_0};
    tbl[4] = '{8'h3C, 1'b1, 10'b1_00111100_0};
    tbl[5] = '{8'h81, 1'b0, 10'b1_10000001_0};
    repeat (3) @(negedge clk);
    check("reset serial", 32'(serial), 32'd1);
    check("reset ready", 32'(ready), 32'd0);
    check("reset active", 32'(active), 32'd0);
    check("reset done", 32'(done), 32'd0);
    rst = 1'b0;
    #1;
    check("ready same cycle reset drops", 32'(ready), 32'd0);
    @(negedge clk);
    check("ready after reset", 32'(ready), 32'd1);
    rx_en = 1'b1;
    send(8'hA5, 1'b0, 1'b1);
    check_frame(8'hA5, cap);
    send(8'h00, 1'b1, 1'b1);
    check_frame(8'h00, cap);
    send(8'hFF, 1'b0, 1'b1);
    check_frame(8'hFF, cap);
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].d, tbl[i].keep, 1'b1);
      check_frame(tbl[i].d, cap);
`ifndef UART_TX_PARITY_EN
      check("table frame", 32'(cap), 32'(tbl[i].frame));
`endif
    end
    valid = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check("ready while disabled", 32'(ready), 32'd0);
    enable = 1'b1;
    valid = 1'b1;
    data = 8'h3C;
    #1;
    check("ready as enable rises", 32'(ready), 32'd0);
    @(negedge clk);
    check("ready cycle after enable", 32'(ready), 32'd1);
    check("not accepted yet", 32'(serial), 32'd1);
    q.push_back(8'h3C);
    sent++;
    @(negedge clk);
    valid = 1'b0;
    check_frame(8'h3C, cap);
    check("scoreboard drained", 32'(q.size()), 32'd0);
    check("rx word count", 32'(rx_words), 32'(sent));
    rx_en = 1'b0;
    send(8'hA5, 1'b0, 1'b0);
    repeat (4 * OS + 4) @(negedge clk);
    check("serial at data bit 3", 32'(serial), 32'(exp_bit(8'hA5, 4)));
    enable = 1'b0;
    @(negedge clk);
    check("abort serial", 32'(serial), 32'd1);
    check("abort active", 32'(active), 32'd0);
    check("abort ready", 32'(ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("abort no done", 32'(done), 32'd0);
      @(negedge clk);
    end
    enable = 1'b1;
    #1;
    check("abort ready as enable returns", 32'(ready), 32'd0);
    @(negedge clk);
    check("abort ready after enable", 32'(ready), 32'd1);
    check("abort idle after enable", 32'(active), 32'd0);
    send(8'h5A, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midframe reset serial", 32'(serial), 32'd1);
    check("midframe reset ready", 32'(ready), 32'd0);
    check("midframe reset active", 32'(active), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready while reset drops", 32'(ready), 32'd0);
    @(negedge clk);
    check("ready after midframe reset", 32'(ready), 32'd1);
    rx_en = 1'b1;
    send(8'h55, 1'b0, 1'b1);
    check_frame(8'h55, cap);
    check("final scoreboard drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
